// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute stage for the multi-cycle MIPS datapath.
// Purpose: ALU-control decode, combinational ALU, and an iterative
// multiply/divide engine that owns the HI/LO registers.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   ALUOp[1:0], func[5:0] decode inputs (00 add, 01 sub, 1x R-type)
//   A, B                  operands (rs, rt/imm)
//   start                 engine request (mult/multu/div/divu/mthi/mtlo)
//   ALUCtrl, Result, Zero combinational ALU outputs (mfhi/mflo override)
//   HI, LO                HI/LO registers
//   busy, done, div_zero  engine status (registered)
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             start,
  output logic [2:0]       ALUCtrl,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   hi_q, lo_q, bmag_q, quo_q;
  logic [WIDTH:0]     rem_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q, done_q, dz_q, neg_q, remneg_q, isdiv_q;

  logic [WIDTH-1:0]   alu_res;
  logic               eng_req, signed_op;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_acc, div_shift, div_trial, rem_d;
  logic [WIDTH-1:0]   quo_d, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;

  // ALU control decode
  always_comb begin
    ALUCtrl = 3'b100;
    if (ALUOp == 2'b01) begin
      ALUCtrl = 3'b110;
    end else if (ALUOp[1]) begin
      case (func)
        F_ADD:   ALUCtrl = 3'b100;
        F_ADDU:  ALUCtrl = 3'b101;
        F_SUB:   ALUCtrl = 3'b110;
        F_AND:   ALUCtrl = 3'b000;
        F_OR:    ALUCtrl = 3'b001;
        F_NOR:   ALUCtrl = 3'b010;
        F_SLT:   ALUCtrl = 3'b011;
        F_SLTU:  ALUCtrl = 3'b111;
        default: ALUCtrl = 3'b100;
      endcase
    end
  end

  // Combinational ALU; mfhi/mflo read the committed HI/LO
  always_comb begin
    case (ALUCtrl)
      3'b000:  alu_res = A & B;
      3'b001:  alu_res = A | B;
      3'b010:  alu_res = ~(A | B);
      3'b011:  alu_res = WIDTH'($signed(A) < $signed(B));
      3'b110:  alu_res = A - B;
      3'b111:  alu_res = WIDTH'(A < B);
      default: alu_res = A + B;
    endcase
    Result = alu_res;
    if (ALUOp[1] && func == F_MFHI) begin
      Result = hi_q;
    end else if (ALUOp[1] && func == F_MFLO) begin
      Result = lo_q;
    end
  end

  assign Zero = (Result == '0);

  // Engine request qualification and operand magnitudes
  always_comb begin
    eng_req   = start && ALUOp[1] &&
                (func inside {F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO});
    signed_op = ~func[0];
    a_mag     = (signed_op && A[WIDTH-1]) ? -A : A;
    b_mag     = (signed_op && B[WIDTH-1]) ? -B : B;
  end

  // One iteration step: shift-add multiply or restoring divide
  always_comb begin
    mul_acc   = quo_q[0] ? (rem_q + {1'b0, bmag_q}) : rem_q;
    div_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, bmag_q};
    if (state_q == S_DIV) begin
      // Negative trial (MSB set) means the divisor did not fit: restore
      if (div_trial[WIDTH]) begin
        rem_d = div_shift;
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end else begin
        rem_d = div_trial;
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      rem_d = {1'b0, mul_acc[WIDTH:1]};
      quo_d = {mul_acc[0], quo_q[WIDTH-1:1]};
    end
  end

  // Sign correction applied in FIX
  always_comb begin
    prod     = {rem_q[WIDTH-1:0], quo_q};
    prod_fix = neg_q ? -prod : prod;
    if (isdiv_q) begin
      fix_lo = neg_q ? -quo_q : quo_q;
      fix_hi = remneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    end else begin
      fix_lo = prod_fix[WIDTH-1:0];
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  // Engine FSM, HI/LO and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      bmag_q   <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      neg_q    <= 1'b0;
      remneg_q <= 1'b0;
      isdiv_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (eng_req) begin
            dz_q <= 1'b0;
            if (func == F_MTHI) begin
              hi_q <= A;
            end else if (func == F_MTLO) begin
              lo_q <= A;
            end else if (func[1] && B == '0) begin
              // Divide by zero finishes immediately without iterating
              lo_q    <= '1;
              hi_q    <= A;
              dz_q    <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              rem_q    <= '0;
              quo_q    <= a_mag;
              bmag_q   <= b_mag;
              neg_q    <= signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
              remneg_q <= signed_op && A[WIDTH-1];
              isdiv_q  <= func[1];
              cnt_q    <= '0;
              busy_q   <= 1'b1;
              state_q  <= func[1] ? S_DIV : S_MUL;
            end
          end
        end
        S_MUL, S_DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_q   <= '0;
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_FIX: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign HI       = hi_q;
  assign LO       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: table-driven and randomized checks of alu_exec_unit
// against a plain-arithmetic reference model.
module tb_alu_exec_unit;

  localparam int unsigned W = 32;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    ALUOp;
  logic [5:0]    func;
  logic [W-1:0]  A, B;
  logic          start;
  logic [2:0]    ALUCtrl;
  logic [W-1:0]  Result, HI, LO;
  logic          Zero, busy, done, div_zero;

  int checks = 0;
  int errors = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .ALUOp(ALUOp), .func(func), .A(A), .B(B),
    .start(start), .ALUCtrl(ALUCtrl), .Result(Result), .Zero(Zero),
    .HI(HI), .LO(LO), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference ALU from the decode table
  function automatic void alu_ref(input logic [1:0] op, input logic [5:0] fn,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [2:0] c, output logic [31:0] r);
    c = 3'b100; r = a + b;
    if (op == 2'b01) begin
      c = 3'b110; r = a - b;
    end else if (op[1]) begin
      case (fn)
        6'b100001: c = 3'b101;
        6'b100010: begin c = 3'b110; r = a - b; end
        6'b100100: begin c = 3'b000; r = a & b; end
        6'b100101: begin c = 3'b001; r = a | b; end
        6'b100111: begin c = 3'b010; r = ~(a | b); end
        6'b101010: begin c = 3'b011; r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
        6'b101011: begin c = 3'b111; r = (a < b) ? 32'd1 : 32'd0; end
        F_MFHI:    r = mhi;
        F_MFLO:    r = mlo;
        default:   ;
      endcase
    end
  endfunction

  // Reference engine using wide native arithmetic
  function automatic void eng_ref(input logic [5:0] f, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] hi,
                                  output logic [31:0] lo, output logic dz);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0; lo = '0; dz = 1'b0;
    case (f)
      F_MULT:  begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      F_MULTU: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
      F_DIV: begin
        if (b == 0) begin lo = '1; hi = a; dz = 1'b1; end
        else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
      end
      F_DIVU: begin
        if (b == 0) begin lo = '1; hi = a; dz = 1'b1; end
        else begin lo = a / b; hi = a % b; end
      end
      default: ;
    endcase
  endfunction

  // Full engine transaction with cycle-accurate busy/done profile
  task automatic run_op(input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
    logic [31:0] eh, el;
    logic edz;
    eng_ref(f, a, b, eh, el, edz);
    @(negedge clk);
    ALUOp = 2'b10; func = f; A = a; B = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; func = F_MFLO;
    if (edz) begin
      @(negedge clk);
      chk({tag, " dz done"}, 32'(done), 32'd1);
      chk({tag, " dz busy"}, 32'(busy), 32'd0);
      chk({tag, " dz HI"}, HI, eh);
      chk({tag, " dz LO"}, LO, el);
      chk({tag, " dz flag"}, 32'(div_zero), 32'd1);
    end else begin
      for (int k = 1; k <= int'(W) + 1; k++) begin
        @(negedge clk);
        chk({tag, " busy run"}, 32'(busy), 32'd1);
        chk({tag, " done run"}, 32'(done), 32'd0);
        chk({tag, " mflo old"}, Result, mlo);
      end
      @(negedge clk);
      chk({tag, " done"}, 32'(done), 32'd1);
      chk({tag, " busy end"}, 32'(busy), 32'd0);
      chk({tag, " HI"}, HI, eh);
      chk({tag, " LO"}, LO, el);
      chk({tag, " dz clr"}, 32'(div_zero), 32'd0);
      chk({tag, " mflo new"}, Result, el);
    end
    mhi = eh; mlo = el;
    @(negedge clk);
    chk({tag, " done pulse"}, 32'(done), 32'd0);
  endtask

  task automatic run_mt(input logic [5:0] f, input logic [31:0] a, input string tag);
    @(negedge clk);
    ALUOp = 2'b10; func = f; A = a; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; func = F_MFHI;
    if (f == F_MTHI) mhi = a; else mlo = a;
    @(negedge clk);
    chk({tag, " HI"}, HI, mhi);
    chk({tag, " LO"}, LO, mlo);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " mfhi"}, Result, mhi);
    @(negedge clk);
    chk({tag, " done later"}, 32'(done), 32'd0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
    logic [31:0] res;
  } alu_vec_t;

  alu_vec_t vecs[13];

  initial begin
    logic [2:0]  ec;
    logic [31:0] er;
    logic [5:0]  fl[12];
    logic [5:0]  ef[4];
    logic [31:0] ra, rb;
    int          seen_done;

    vecs[0]  = '{2'b10, 6'b100010, 32'd5, 32'd5, 3'b110, 32'd0};
    vecs[1]  = '{2'b10, 6'b101011, 32'd1, 32'hFFFFFFFF, 3'b111, 32'd1};
    vecs[2]  = '{2'b00, 6'b000000, 32'd3, 32'd4, 3'b100, 32'd7};
    vecs[3]  = '{2'b01, 6'b100100, 32'd10, 32'd3, 3'b110, 32'd7};
    vecs[4]  = '{2'b10, 6'b100000, 32'h7FFFFFFF, 32'd1, 3'b100, 32'h80000000};
    vecs[5]  = '{2'b10, 6'b100001, 32'hFFFFFFFF, 32'd2, 3'b101, 32'd1};
    vecs[6]  = '{2'b10, 6'b100100, 32'h0000F0F0, 32'h0000FF00, 3'b000, 32'h0000F000};
    vecs[7]  = '{2'b10, 6'b100101, 32'h0000F0F0, 32'h00000F0F, 3'b001, 32'h0000FFFF};
    vecs[8]  = '{2'b10, 6'b100111, 32'd0, 32'd0, 3'b010, 32'hFFFFFFFF};
    vecs[9]  = '{2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1, 3'b011, 32'd1};
    vecs[10] = '{2'b10, 6'b101011, 32'hFFFFFFFF, 32'd1, 3'b111, 32'd0};
    vecs[11] = '{2'b10, 6'b111111, 32'd2, 32'd3, 3'b100, 32'd5};
    vecs[12] = '{2'b10, 6'b101010, 32'd1, 32'hFFFFFFFF, 3'b011, 32'd0};

    fl = '{6'b100000, 6'b100001, 6'b100010, 6'b100100, 6'b100101, 6'b100111,
           6'b101010, 6'b101011, F_MFHI, F_MFLO, 6'b000000, F_MULT};
    ef = '{F_MULT, F_MULTU, F_DIV, F_DIVU};

    reset = 1'b1; ALUOp = 2'b00; func = '0; A = '0; B = '0; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst HI", HI, 32'd0);
    chk("rst LO", LO, 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst dz", 32'(div_zero), 32'd0);
    reset = 1'b0;

    // Directed ALU table
    foreach (vecs[i]) begin
      @(negedge clk);
      ALUOp = vecs[i].op; func = vecs[i].fn; A = vecs[i].a; B = vecs[i].b;
      #1;
      chk($sformatf("alu%0d ctrl", i), 32'(ALUCtrl), 32'(vecs[i].ctrl));
      chk($sformatf("alu%0d res", i), Result, vecs[i].res);
      chk($sformatf("alu%0d zero", i), 32'(Zero), 32'(vecs[i].res == 0));
    end

    // Randomized ALU against the model
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ALUOp = 2'($urandom_range(0, 3));
      func  = fl[$urandom_range(0, 11)];
      A = $urandom; B = (i % 5 == 0) ? A : $urandom;
      #1;
      alu_ref(ALUOp, func, A, B, ec, er);
      chk($sformatf("ralu%0d ctrl", i), 32'(ALUCtrl), 32'(ec));
      chk($sformatf("ralu%0d res", i), Result, er);
    end

    // Directed engine cases
    run_op(F_MULT,  32'hFFFFFFFD, 32'd5,       "mult -3*5");
    chk("mult -3*5 HI const", HI, 32'hFFFFFFFF);
    chk("mult -3*5 LO const", LO, 32'hFFFFFFF1);
    run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu max");
    chk("multu HI const", HI, 32'hFFFFFFFE);
    chk("multu LO const", LO, 32'd1);
    run_op(F_DIVU,  32'd100,      32'd7,       "divu 100/7");
    chk("divu LO const", LO, 32'd14);
    chk("divu HI const", HI, 32'd2);
    run_op(F_DIV,   32'hFFFFFFF9, 32'd2,       "div -7/2");
    chk("div -7/2 LO const", LO, 32'hFFFFFFFD);
    chk("div -7/2 HI const", HI, 32'hFFFFFFFF);
    run_op(F_DIV,   32'h80000000, 32'hFFFFFFFF, "div min/-1");
    chk("div min LO const", LO, 32'h80000000);
    chk("div min HI const", HI, 32'd0);
    run_op(F_DIV,   32'd9,        32'd0,       "div 9/0");
    chk("div0 HI const", HI, 32'd9);
    run_op(F_DIV,   32'd20,       32'hFFFFFFFB, "div 20/-5");
    run_op(F_MULT,  32'h80000000, 32'h80000000, "mult min*min");

    run_mt(F_MTHI, 32'hCAFEF00D, "mthi");
    run_mt(F_MTLO, 32'h12345678, "mtlo");

    // Starts during a running mult are ignored
    @(negedge clk);
    ALUOp = 2'b10; func = F_MULT; A = 32'd7; B = 32'd6; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; func = F_MFLO;
    for (int k = 1; k <= int'(W) + 1; k++) begin
      @(negedge clk);
      chk("ign busy", 32'(busy), 32'd1);
      chk("ign done", 32'(done), 32'd0);
      chk("ign LO old", LO, mlo);
      chk("ign HI old", HI, mhi);
      chk("ign dz", 32'(div_zero), 32'd0);
      if (k < 5 || k > 8) chk("ign mflo old", Result, mlo);
      if (k == 5) begin start = 1'b1; func = F_MTLO; A = 32'h0000DEAD; end
      if (k == 6) begin func = F_DIV; B = 32'd0; end
      if (k == 8) begin start = 1'b0; func = F_MFLO; end
    end
    @(negedge clk);
    chk("ign final done", 32'(done), 32'd1);
    chk("ign final LO", LO, 32'd42);
    chk("ign final HI", HI, 32'd0);
    chk("ign final dz", 32'(div_zero), 32'd0);
    mhi = 32'd0; mlo = 32'd42;
    @(negedge clk);
    chk("ign done pulse", 32'(done), 32'd0);

    // Reset abandons a running mult
    run_mt(F_MTHI, 32'h55AA55AA, "mthi pre-rst");
    @(negedge clk);
    ALUOp = 2'b10; func = F_MULT; A = 32'd3; B = 32'd11; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    chk("rst mid busy before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst mid busy", 32'(busy), 32'd0);
    chk("rst mid done", 32'(done), 32'd0);
    chk("rst mid HI", HI, 32'd0);
    chk("rst mid LO", LO, 32'd0);
    reset = 1'b0;
    mhi = '0; mlo = '0;
    seen_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    chk("rst no done", 32'(seen_done), 32'd0);
    run_op(F_MULTU, 32'd123456, 32'd654321, "multu post-rst");

    // Randomized engine ops against the model
    for (int i = 0; i < 12; i++) begin
      ra = (i % 4 == 3) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      run_op(ef[$urandom_range(0, 3)], ra, rb, $sformatf("reng%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised execute unit for the multi-cycle MIPS datapath. It combines the ALU-control decode and a combinational ALU with an iterative multiply/divide engine that owns the HI/LO registers. Decode takes `ALUOp`/`func` and produces `ALUCtrl`; a 3-bit encoding extends the existing decoder with nor/sltu. Mult/div run over WIDTH cycles behind a start/busy/done handshake, which the main control FSM waits on.

## Interface
- WIDTH, 32: datapath width; must be ≥ 4.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- ALUOp  in  2  00 = add (lw/sw/PC), 01 = sub (beq), 1x = R-type via func
- func  in  6  R-type function field
- A  in  WIDTH  operand rs
- B  in  WIDTH  operand rt / immediate
- start  in  1  request for mult/multu/div/divu/mthi/mtlo; sampled only in IDLE
- ALUCtrl  out  3  decoded ALU operation, combinational
- Result  out  WIDTH  ALU result, or HI/LO for mfhi/mflo, combinational
- Zero  out  1  Result == 0
- HI, LO  out  WIDTH  HI/LO registers
- busy  out  1  engine running
- done  out  1  one-cycle pulse when HI/LO hold the new result
- div_zero  out  1  sticky until next accepted start; last div had B == 0

## Operation
- Decode for ALUOp=1x maps func to ALUCtrl and operation:
  - 100000 → 100, add
  - 100001 → 101, addu
  - 100010 → 110, sub
  - 100100 → 000, and
  - 100101 → 001, or
  - 100111 → 010, nor
  - 101010 → 011, slt (signed)
  - 101011 → 111, sltu
  - any other func → 100, Result = A+B.
- ALUOp=00 → ALUCtrl 100. ALUOp=01 → ALUCtrl 110.
- Overflow is not trapped. add and addu differ only in the ALUCtrl code.
- mfhi (010000) forces Result=HI. mflo (010010) forces Result=LO. ALUCtrl=100 in both cases.
- Engine functions: mult 011000, multu 011001, div 011010, divu 011011, mthi 010001, mtlo 010011. They require ALUOp=1x and start=1 in IDLE.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
  - IDLE → MUL for mult/multu. IDLE → DIV for div/divu with B≠0. IDLE → DONE for div/divu with B=0.
  - mthi/mtlo write HI=A or LO=A at that edge and stay in IDLE. They raise no done.
  - MUL/DIV: an iteration counter runs 0..WIDTH-1, then the FSM goes to FIX.
  - FIX: sign correction, HI/LO written, then DONE. DONE → IDLE after one cycle.
- On accept, the operands are latched. For signed ops, absolute values are taken; the unsigned magnitude of -2^(WIDTH-1) is valid.
- Multiply: shift-add, one bit per cycle, 2·WIDTH product. If operand signs differ (signed only), the product is negated in FIX. {HI,LO}=product.
- Divide: restoring, one quotient bit per cycle. Quotient is negated if signs differ. Remainder takes the sign of the dividend. LO=quotient, HI=remainder.
  - -2^(W-1) / -1 yields LO=-2^(W-1), HI=0.
- Divide by zero: no iteration. LO=all ones, HI=A, div_zero=1, all written on the IDLE→DONE edge.
- start while not IDLE: ignored entirely. mthi/mtlo while busy are also ignored.
- Combinational ALU and mfhi/mflo stay usable while busy; mfhi/mflo read the old HI/LO until done.

## Timing
- Reset (sync, priority over everything): state=IDLE, HI=LO=0, busy=0, done=0, div_zero=0, counter=0. An operation in flight is abandoned and HI/LO are cleared.
- ALUCtrl/Result/Zero: combinational, no register stage.
- Accepted start at edge N:
  - busy=1 from cycle N+1 through N+WIDTH+1 (MUL/DIV WIDTH cycles, then FIX).
  - HI/LO are updated at the edge ending FIX.
  - done=1 and busy=0 in cycle N+WIDTH+2.
- Divide by zero: busy never asserts. HI/LO are updated at edge N. done=1 in cycle N+1.
- mthi/mtlo: HI/LO are updated at edge N. No busy and no done.
- A new start is accepted in the DONE cycle's successor (IDLE) at the earliest. done never coincides with busy.

## Test plan
- ALU decode, ALUOp=10, func=100010, A=5, B=5 → ALUCtrl=110, Result=0, Zero=1. func=101011, A=1, B=0xFFFFFFFF → ALUCtrl=111, Result=1.
- mult, A=-3, B=5, WIDTH=32, start at edge N → busy for cycles N+1..N+33, done at N+34, HI=0xFFFFFFFF, LO=0xFFFFFFF1. multu, A=B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=1.
- divu 100/7 → LO=14, HI=2. div -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. div 0x80000000/-1 → LO=0x80000000, HI=0.
- div A=9, B=0 → done at N+1 with busy=0 throughout, LO=0xFFFFFFFF, HI=9, div_zero=1. A following valid div clears div_zero.
- Start mult, then assert mtlo start and a new div start mid-run → both ignored; only the mult result lands. mflo during the run returns the old LO.
- Start mult, then assert reset at cycle N+10 → next cycle state IDLE, busy=0, HI=LO=0, no done pulse. A new multu completes normally.
